// File: rtl/uart8_pkg.sv
// uart8_pkg: FSM encodings and shared constants for the uart8 8N1 UART.
// Imported by uart8 and uart8_baud_gen.
package uart8_pkg;

  localparam int OVERSAMPLE = 16;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } tx_state_e;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_e;

  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart8_baud_gen.sv
// uart8_baud_gen: TX bit tick and RX 16x oversample tick.
// Each counter holds at zero while its run input is low, so every frame restarts phase.
module uart8_baud_gen
  import uart8_pkg::*;
#(
  parameter int CLOCK_RATE = 12000000,
  parameter int BAUD_RATE  = 9600
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tx_run,
  input  logic rx_run,
  output logic tx_tick,
  output logic rx_tick
);

  localparam int TX_DIV = CLOCK_RATE / BAUD_RATE;
  localparam int RX_DIV = CLOCK_RATE / (BAUD_RATE * OVERSAMPLE);
  localparam int TXW = cnt_w(TX_DIV);
  localparam int RXW = cnt_w(RX_DIV);
  localparam logic [TXW-1:0] TX_LAST = TXW'(TX_DIV - 1);
  localparam logic [RXW-1:0] RX_LAST = RXW'(RX_DIV - 1);

  logic [TXW-1:0] tx_cnt_q, tx_cnt_d;
  logic [RXW-1:0] rx_cnt_q, rx_cnt_d;

  assign tx_tick = tx_run && (tx_cnt_q == TX_LAST);
  assign rx_tick = rx_run && (rx_cnt_q == RX_LAST);

  always_comb begin
    tx_cnt_d = '0;
    rx_cnt_d = '0;
    if (tx_run && !tx_tick) tx_cnt_d = tx_cnt_q + 1'b1;
    if (rx_run && !rx_tick) rx_cnt_d = rx_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_cnt_q <= '0;
      rx_cnt_q <= '0;
    end else begin
      tx_cnt_q <= tx_cnt_d;
      rx_cnt_q <= rx_cnt_d;
    end
  end

endmodule

// File: rtl/uart8.sv
// uart8: 8N1 UART with fully independent transmitter and receiver.
// Define UART8_RX_MAJORITY_EN to vote rx bits over oversample ticks 7, 8, 9.
module uart8
  import uart8_pkg::*;
#(
  parameter int CLOCK_RATE = 12000000,
  parameter int BAUD_RATE  = 9600
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rxEn,
  input  logic       rx,
  output logic       rxBusy,
  output logic       rxDone,
  output logic       rxErr,
  output logic [7:0] out,
  input  logic       txEn,
  input  logic       txStart,
  input  logic [7:0] in,
  output logic       txBusy,
  output logic       txDone,
  output logic       tx
);

  tx_state_e  tx_st_q, tx_st_d;
  logic [7:0] tx_sh_q, tx_sh_d;
  logic [2:0] tx_idx_q, tx_idx_d;
  logic       tx_done_q, tx_done_d;
  logic       tx_tick, tx_run;

  rx_state_e  rx_st_q, rx_st_d;
  logic       rx_m_q, rx_s_q, rx_p_q;
  logic [3:0] rx_ph_q, rx_ph_d;
  logic [2:0] rx_idx_q, rx_idx_d;
  logic [7:0] rx_sh_q, rx_sh_d;
  logic [7:0] out_q, out_d;
  logic       rx_s8_q, rx_s8_d;
  logic       rx_done_q, rx_done_d;
  logic       rx_err_q, rx_err_d;
  logic       rx_tick, rx_run;
  logic       rx_fall, rx_dec, rx_bit;

  assign tx_run = txEn && (tx_st_q != TX_IDLE);
  assign rx_run = rxEn && (rx_st_q != RX_IDLE);

  uart8_baud_gen #(
    .CLOCK_RATE(CLOCK_RATE),
    .BAUD_RATE (BAUD_RATE)
  ) u_baud (
    .clk    (clk),
    .rst_n  (rst_n),
    .tx_run (tx_run),
    .rx_run (rx_run),
    .tx_tick(tx_tick),
    .rx_tick(rx_tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_st_q   <= TX_IDLE;
      tx_sh_q   <= '0;
      tx_idx_q  <= '0;
      tx_done_q <= 1'b0;
    end else begin
      tx_st_q   <= tx_st_d;
      tx_sh_q   <= tx_sh_d;
      tx_idx_q  <= tx_idx_d;
      tx_done_q <= tx_done_d;
    end
  end

  always_comb begin
    tx_st_d   = tx_st_q;
    tx_sh_d   = tx_sh_q;
    tx_idx_d  = tx_idx_q;
    tx_done_d = 1'b0;
    if (!txEn) begin
      tx_st_d = TX_IDLE;
    end else begin
      unique case (tx_st_q)
        TX_IDLE: if (txStart) begin
          tx_st_d  = TX_START;
          tx_sh_d  = in;
          tx_idx_d = '0;
        end
        TX_START: if (tx_tick) tx_st_d = TX_DATA;
        TX_DATA: if (tx_tick) begin
          tx_sh_d  = {1'b0, tx_sh_q[7:1]};
          tx_idx_d = tx_idx_q + 1'b1;
          if (tx_idx_q == 3'd7) tx_st_d = TX_STOP;
        end
        TX_STOP: if (tx_tick) begin
          tx_st_d   = TX_IDLE;
          tx_done_d = 1'b1;
        end
        default: tx_st_d = TX_IDLE;
      endcase
    end
  end

  // txEn gates the line combinationally so a disable idles tx at once
  always_comb begin
    tx     = 1'b1;
    txBusy = 1'b0;
    if (txEn) begin
      unique case (tx_st_q)
        TX_START: begin tx = 1'b0;       txBusy = 1'b1; end
        TX_DATA:  begin tx = tx_sh_q[0]; txBusy = 1'b1; end
        TX_STOP:  begin tx = 1'b1;       txBusy = 1'b1; end
        default:  begin tx = 1'b1;       txBusy = 1'b0; end
      endcase
    end
  end

  assign txDone = tx_done_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_m_q    <= 1'b1;
      rx_s_q    <= 1'b1;
      rx_p_q    <= 1'b1;
      rx_st_q   <= RX_IDLE;
      rx_ph_q   <= '0;
      rx_idx_q  <= '0;
      rx_sh_q   <= '0;
      out_q     <= '0;
      rx_s8_q   <= 1'b1;
      rx_done_q <= 1'b0;
      rx_err_q  <= 1'b0;
    end else begin
      rx_m_q    <= rx;
      rx_s_q    <= rx_m_q;
      rx_p_q    <= rx_s_q;
      rx_st_q   <= rx_st_d;
      rx_ph_q   <= rx_ph_d;
      rx_idx_q  <= rx_idx_d;
      rx_sh_q   <= rx_sh_d;
      out_q     <= out_d;
      rx_s8_q   <= rx_s8_d;
      rx_done_q <= rx_done_d;
      rx_err_q  <= rx_err_d;
    end
  end

  assign rx_fall = rx_p_q & ~rx_s_q;
  // ph counts completed ticks; ph==8 at a tick is oversample tick 9
  assign rx_dec  = rx_tick && (rx_ph_q == 4'd8);

`ifdef UART8_RX_MAJORITY_EN
  logic rx_s7_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rx_s7_q <= 1'b1;
    else if (rx_tick && rx_ph_q == 4'd6) rx_s7_q <= rx_s_q;
  end

  assign rx_bit = (rx_s7_q & rx_s8_q) | (rx_s7_q & rx_s_q) |
                  (rx_s8_q & rx_s_q);
`else
  assign rx_bit = rx_s8_q;
`endif

  always_comb begin
    rx_st_d   = rx_st_q;
    rx_ph_d   = rx_ph_q;
    rx_idx_d  = rx_idx_q;
    rx_sh_d   = rx_sh_q;
    out_d     = out_q;
    rx_s8_d   = rx_s8_q;
    rx_done_d = 1'b0;
    rx_err_d  = 1'b0;
    if (rx_tick) rx_ph_d = rx_ph_q + 1'b1;
    if (rx_tick && rx_ph_q == 4'd7) rx_s8_d = rx_s_q;
    if (!rxEn) begin
      rx_st_d = RX_IDLE;
      rx_ph_d = '0;
    end else begin
      unique case (rx_st_q)
        RX_IDLE: begin
          rx_ph_d = '0;
          if (rx_fall) begin
            rx_st_d  = RX_START;
            rx_idx_d = '0;
          end
        end
        RX_START: if (rx_dec) rx_st_d = rx_bit ? RX_IDLE : RX_DATA;
        RX_DATA: if (rx_dec) begin
          rx_sh_d  = {rx_bit, rx_sh_q[7:1]};
          rx_idx_d = rx_idx_q + 1'b1;
          if (rx_idx_q == 3'd7) rx_st_d = RX_STOP;
        end
        RX_STOP: if (rx_dec) begin
          rx_st_d = RX_IDLE;
          if (rx_bit) begin
            out_d     = rx_sh_q;
            rx_done_d = 1'b1;
          end else begin
            rx_err_d = 1'b1;
          end
        end
        default: rx_st_d = RX_IDLE;
      endcase
    end
  end

  always_comb begin
    rxBusy = rxEn && (rx_st_q != RX_IDLE);
    rxDone = rx_done_q;
    rxErr  = rx_err_q;
    out    = out_q;
  end

endmodule

// File: tb/tb_uart8.sv
// tb_uart8: randomized scoreboard bench for uart8 (loopback and direct rx drive).
// A line-level TX decoder and an rx event monitor pop expectations from queues.
module tb_uart8;

  localparam int CLK_HZ = 3200000;
  localparam int BAUD   = 100000;
  localparam int TXD    = CLK_HZ / BAUD;
  localparam int RXD    = TXD / 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rxEn = 1'b0;
  logic       txEn = 1'b0;
  logic       txStart = 1'b0;
  logic [7:0] din = 8'h00;
  logic       rxBusy, rxDone, rxErr, txBusy, txDone, tx;
  logic [7:0] out;
  logic       loop = 1'b0;
  logic       tb_rx = 1'b1;
  logic       rx_line;

  int         checks = 0;
  int         failures = 0;
  logic [7:0] tx_exp[$];
  logic [8:0] rx_exp[$];
  int         txdone_cnt = 0;
  int         exp_txdone = 0;
  logic [7:0] model_out = 8'h00;
  logic       busy_seen = 1'b0;

  assign rx_line = loop ? tx : tb_rx;

  always #5 clk = ~clk;

  uart8 #(
    .CLOCK_RATE(CLK_HZ),
    .BAUD_RATE (BAUD)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .rxEn   (rxEn),
    .rx     (rx_line),
    .rxBusy (rxBusy),
    .rxDone (rxDone),
    .rxErr  (rxErr),
    .out    (out),
    .txEn   (txEn),
    .txStart(txStart),
    .in     (din),
    .txBusy (txBusy),
    .txDone (txDone),
    .tx     (tx)
  );

  function automatic void chk(input string n, input logic [31:0] a,
                              input logic [31:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
    end
  endfunction

  initial begin : rx_mon
    logic [8:0] e;
    forever begin
      @(negedge clk);
      if (txDone) txdone_cnt++;
      if (rxBusy) busy_seen = 1'b1;
      if (rxDone || rxErr) begin
        if (rx_exp.size() == 0) begin
          chk("rx_unexpected_event", {30'd0, rxErr, rxDone}, 32'd0);
        end else begin
          e = rx_exp.pop_front();
          chk("rx_kind", {30'd0, rxErr, rxDone}, e[8] ? 32'd2 : 32'd1);
          chk("rx_out", {24'd0, out}, {24'd0, e[7:0]});
        end
      end
    end
  end

  initial begin : tx_mon
    logic [9:0] bits;
    logic       ok;
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (rst_n && txBusy && !tx) begin
        ok = 1'b1;
        bits = '0;
        for (int t = 1; t <= 10 * TXD && ok; t++) begin
          @(negedge clk);
          if (t < 10 * TXD && !txBusy) begin
            ok = 1'b0;
          end else begin
            if (t % TXD == TXD / 2) bits[t/TXD] = tx;
            if (t == 10 * TXD - 1) chk("tx_done_early", {31'd0, txDone}, 32'd0);
          end
        end
        if (ok) begin
          chk("tx_frame_end", {30'd0, txBusy, txDone}, 32'd1);
          if (tx_exp.size() == 0) begin
            chk("tx_unexpected_frame", tx_exp.size(), 32'd1);
          end else begin
            e = tx_exp.pop_front();
            chk("tx_frame_bits", {22'd0, bits}, {22'd0, 1'b1, e, 1'b0});
          end
        end
      end
    end
  end

  initial begin : watchdog
    #5ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drain(input int budget);
    int k;
    k = 0;
    while ((tx_exp.size() != 0 || rx_exp.size() != 0 || txBusy || rxBusy)
           && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk("drain_in_budget", {31'd0, k < budget}, 32'd1);
  endtask

  task automatic send_tx(input logic [7:0] b, input bit expect_rx);
    tx_exp.push_back(b);
    exp_txdone++;
    if (expect_rx) begin
      rx_exp.push_back({1'b0, b});
      model_out = b;
    end
    din = b;
    txStart = 1'b1;
    tick(1);
    txStart = 1'b0;
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stop);
    logic [9:0] f;
    f = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      tb_rx = f[i];
      tick(TXD);
    end
    tb_rx = 1'b1;
    tick(2 * TXD);
  endtask

  task automatic chk_reset_outputs();
    chk("rst_tx", {31'd0, tx}, 32'd1);
    chk("rst_txBusy", {31'd0, txBusy}, 32'd0);
    chk("rst_txDone", {31'd0, txDone}, 32'd0);
    chk("rst_rxBusy", {31'd0, rxBusy}, 32'd0);
    chk("rst_rxDone", {31'd0, rxDone}, 32'd0);
    chk("rst_rxErr", {31'd0, rxErr}, 32'd0);
    chk("rst_out", {24'd0, out}, 32'd0);
  endtask

  initial begin : stim
    logic [7:0] a, b;
    logic       stop;
    int         k;

    tick(3);
    chk_reset_outputs();
    rst_n = 1'b1;
    rxEn = 1'b1;
    txEn = 1'b1;
    tick(2);

    // 0x45 looped back, txStart held for three bit times
    loop = 1'b1;
    tx_exp.push_back(8'h45);
    exp_txdone++;
    rx_exp.push_back({1'b0, 8'h45});
    model_out = 8'h45;
    din = 8'h45;
    txStart = 1'b1;
    tick(3 * TXD);
    txStart = 1'b0;
    drain(20 * TXD);
    chk("out_45", {24'd0, out}, 32'h45);
    chk("txdone_after_45", txdone_cnt, exp_txdone);

    // back-to-back frames; in changes mid-frame and only the next frame sees it
    a = 8'($urandom);
    b = 8'($urandom);
    tx_exp.push_back(a);
    tx_exp.push_back(b);
    rx_exp.push_back({1'b0, a});
    rx_exp.push_back({1'b0, b});
    exp_txdone += 2;
    model_out = b;
    din = a;
    txStart = 1'b1;
    tick(3 * TXD);
    din = b;
    k = 0;
    while (!txDone && k < 12 * TXD) begin
      tick(1);
      k++;
    end
    chk("b2b_first_done", {31'd0, txDone}, 32'd1);
    tick(TXD);
    txStart = 1'b0;
    drain(25 * TXD);

    for (int i = 0; i < 10; i++) begin
      send_tx(8'($urandom), 1'b1);
      drain(15 * TXD);
    end
    chk("out_loop_random", {24'd0, out}, {24'd0, model_out});

    // direct receive: framing error keeps out
    loop = 1'b0;
    tick(2);
    rx_exp.push_back({1'b1, model_out});
    send_rx(8'($urandom), 1'b0);
    drain(5 * TXD);
    chk("out_after_err", {24'd0, out}, {24'd0, model_out});

    // short low pulse rejected as a glitch
    busy_seen = 1'b0;
    tb_rx = 1'b0;
    tick(4 * RXD);
    tb_rx = 1'b1;
    tick(40 * RXD);
    chk("glitch_busy_seen", {31'd0, busy_seen}, 32'd1);
    chk("glitch_busy_clear", {31'd0, rxBusy}, 32'd0);

    // receiver disabled while 0x3C arrives
    rxEn = 1'b0;
    busy_seen = 1'b0;
    send_rx(8'h3C, 1'b1);
    chk("rxen_off_busy", {31'd0, busy_seen}, 32'd0);
    chk("rxen_off_out", {24'd0, out}, {24'd0, model_out});
    rxEn = 1'b1;
    tick(TXD);

    for (int i = 0; i < 8; i++) begin
      a = 8'($urandom);
      stop = ($urandom_range(3) != 0);
      if (stop) begin
        rx_exp.push_back({1'b0, a});
        model_out = a;
      end else begin
        rx_exp.push_back({1'b1, model_out});
      end
      send_rx(a, stop);
      drain(5 * TXD);
    end
    chk("out_direct_random", {24'd0, out}, {24'd0, model_out});

    // txEn dropped during DATA
    din = 8'h96;
    txStart = 1'b1;
    tick(1);
    txStart = 1'b0;
    tick(4 * TXD);
    txEn = 1'b0;
    tick(1);
    chk("txen_off_tx", {31'd0, tx}, 32'd1);
    chk("txen_off_busy", {31'd0, txBusy}, 32'd0);
    tick(12 * TXD);
    chk("txen_off_no_done", txdone_cnt, exp_txdone);
    txEn = 1'b1;
    tick(2);
    send_tx(8'h96, 1'b0);
    drain(15 * TXD);

    // reset in the middle of a looped-back frame
    loop = 1'b1;
    din = 8'h5A;
    txStart = 1'b1;
    tick(1);
    txStart = 1'b0;
    tick(5 * TXD);
    chk("mid_frame_busy", {30'd0, txBusy, rxBusy}, 32'd3);
    rst_n = 1'b0;
    tick(1);
    chk_reset_outputs();
    tick(3);
    rst_n = 1'b1;
    model_out = 8'h00;
    tick(2 * TXD);
    chk("post_rst_no_done", txdone_cnt, exp_txdone);
    chk("post_rst_out", {24'd0, out}, 32'd0);
    send_tx(8'hA5, 1'b1);
    drain(15 * TXD);
    chk("out_a5", {24'd0, out}, 32'hA5);

    tick(TXD);
    chk("tx_queue_empty", tx_exp.size(), 32'd0);
    chk("rx_queue_empty", rx_exp.size(), 32'd0);
    chk("txdone_total", txdone_cnt, exp_txdone);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
